// File: rtl/cnn_obi_fmap_mem.sv
// cnn_obi_fmap_mem: OBI subordinate feature-map memory with
// configurable response latency, outstanding limit and stall.
// Ports: clk_i, rst_i (async high), testmode_i (DFT, unused),
//   obi_req_i/obi_rsp_o (OBI link), stall_i (blocks grants),
//   err_count_o (saturating error responses), busy_o.
package obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   4
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic [0:0]  r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module cnn_obi_fmap_mem
  import obi_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg         = ObiDefaultConfig,
  parameter int unsigned NumWords       = 256,
  parameter logic [31:0] BaseAddr       = 32'h1A10_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        testmode_i,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  input  logic        stall_i,
  output logic [15:0] err_count_o,
  output logic        busy_o
);
  localparam int unsigned AW     = $clog2(NumWords);
  localparam int unsigned IdW    = ObiCfg.IdWidth;
  localparam logic [31:0] Span   = 32'(4 * NumWords);
  localparam logic [2:0]  MaxOut = 3'(MaxOutstanding);
  localparam logic [31:0] ErrWrd = 32'hBADC_AB1E;

  logic [31:0]        mem_q [NumWords];
  logic [31:0]        offset;
  logic [AW-1:0]      widx;
  logic               addr_ok;
  logic               gnt;
  logic               hs;
  logic [31:0]        new_d;
  logic               new_e;
  logic [Latency-1:0] v_q;
  logic [Latency-1:0] e_q;
  logic [31:0]        d_q  [Latency];
  logic [IdW-1:0]     id_q [Latency];
  logic               rsp_v;
  logic [2:0]         out_q, out_d;
  logic [15:0]        ecnt_q, ecnt_d;
  logic               unused_testmode;

  assign unused_testmode = testmode_i;

  assign offset  = obi_req_i.a.addr - BaseAddr;
  assign addr_ok = (obi_req_i.a.addr >= BaseAddr)
                && (offset < Span)
                && (obi_req_i.a.addr[1:0] == 2'b00);
  assign widx    = offset[AW+1:2];

  assign gnt = obi_req_i.req & ~stall_i & ~rst_i
             & (out_q < MaxOut);
  assign hs  = obi_req_i.req & gnt;

  // Response payload is formed at the handshake edge;
  // idle slots carry zero so rdata stays 0 off-rvalid.
  always_comb begin
    new_d = '0;
    new_e = 1'b0;
    if (hs) begin
      if (!addr_ok) begin
        new_d = ErrWrd;
        new_e = 1'b1;
      end else if (!obi_req_i.a.we) begin
        new_d = mem_q[widx];
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (hs && addr_ok && obi_req_i.a.we) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_req_i.a.be[b]) begin
          mem_q[widx][8*b +: 8] <=
            obi_req_i.a.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
      e_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        d_q[i]  <= '0;
        id_q[i] <= '0;
      end
    end else begin
      v_q[0]  <= hs;
      e_q[0]  <= new_e;
      d_q[0]  <= new_d;
      id_q[0] <= hs ? IdW'(obi_req_i.a.aid) : '0;
      for (int i = 1; i < Latency; i++) begin
        v_q[i]  <= v_q[i-1];
        e_q[i]  <= e_q[i-1];
        d_q[i]  <= d_q[i-1];
        id_q[i] <= id_q[i-1];
      end
    end
  end

  assign rsp_v = v_q[Latency-1];

  always_comb begin
    out_d = out_q;
    if (hs && !rsp_v) out_d = out_q + 3'd1;
    if (!hs && rsp_v) out_d = out_q - 3'd1;
  end

  always_comb begin
    ecnt_d = ecnt_q;
    if (rsp_v && e_q[Latency-1] && ecnt_q != 16'hFFFF)
      ecnt_d = ecnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q  <= '0;
      ecnt_q <= '0;
    end else begin
      out_q  <= out_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign obi_rsp_o.gnt          = gnt;
  assign obi_rsp_o.rvalid       = rsp_v;
  assign obi_rsp_o.r.rdata      = d_q[Latency-1];
  assign obi_rsp_o.r.rid        = 4'(id_q[Latency-1]);
  assign obi_rsp_o.r.err        = e_q[Latency-1];
  assign obi_rsp_o.r.r_optional = '0;
  assign err_count_o            = ecnt_q;
  assign busy_o                 = (out_q != 3'd0);
endmodule

// File: doc/cnn_obi_fmap_mem.md
Name: cnn_obi_fmap_mem

Overview:
OBI subordinate feature-map memory that answers the CNN accelerator's manager-port reads and writes (input pixels in, pooled results out). It sits on the accelerator's manager OBI link in place of system SRAM, so the datapath can be brought up and verified standalone. Response latency and grant back-pressure are configurable to exercise the manager FSM's handshake handling.

Parameters:
ObiCfg, obi_pkg::ObiDefaultConfig, OBI widths (AddrWidth, DataWidth=32, IdWidth)
NumWords, 256, storage depth in 32-bit words (power of two, 16..4096)
BaseAddr, 32'h1A10_0000, byte address of word 0
Latency, 1, cycles from grant to rvalid (1..4)
MaxOutstanding, 2, accepted-but-unanswered request limit (1..Latency+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
testmode_i  in  1  unused functionally; reserved for DFT
obi_req_i  in  obi_req_t  OBI request: req, a.addr, a.we, a.be, a.wdata, a.aid
obi_rsp_o  out  obi_rsp_t  OBI response: gnt, rvalid, r.rdata, r.rid, r.err, r.r_optional='0
stall_i  in  1  forces gnt low while high (bench back-pressure)
err_count_o  out  16  saturating count of error responses
busy_o  out  1  high while outstanding count > 0

Behaviour:
- Reset (rst_i high, async): gnt=0 combinationally; rvalid=0, rdata=0, rid=0, err=0, err_count_o=0, busy_o=0, outstanding=0, delay pipeline flushed. Memory array is NOT reset; contents are undefined until written.
- Grant (combinational): gnt = req & ~stall_i & ~rst_i & (outstanding < MaxOutstanding). Handshake = req & gnt.
- Decode: offset = addr - BaseAddr. Valid when addr >= BaseAddr, offset < 4*NumWords, and addr[1:0]==0. Word index = offset[log2(NumWords)+1:2].
- Write at handshake, valid: bytes with be[i]=1 updated in the same clock edge; bytes with be[i]=0 unchanged. Response: rdata=0, err=0.
- Read at handshake, valid: data captured at the handshake edge, so a read accepted in the cycle after a write to the same word returns the new data. Response: rdata=word, err=0.
- Invalid address (read or write): no array access; response rdata=32'hBADC_AB1E, err=1; err_count_o increments, saturating at 16'hFFFF.
- Response timing: each accepted request yields exactly one response, rvalid high for exactly one cycle, Latency cycles after the handshake edge. For example, Latency=1 gives rvalid in the cycle after gnt. Responses are strictly in order. rid equals the accepted a.aid. There is no rready; the manager must sample in the rvalid cycle.
- Pipeline: Latency-deep shift register of {valid, rdata, err, rid}. It advances every cycle, so back-to-back accepts give back-to-back rvalid.
- Outstanding counter: +1 on handshake, -1 on rvalid, unchanged when both occur in the same cycle. It never exceeds MaxOutstanding, which is guaranteed by the gnt rule. busy_o = (outstanding != 0).
- stall_i only blocks new grants. In-flight responses still complete on schedule.
- Reset mid-operation: in-flight responses are discarded and no rvalid follows for them. Writes already accepted remain in the array.
- rdata outside rvalid cycles is held at 0.

Test Plan:
- Reset then idle: rst_i high 3 cycles with req=1 -> gnt=0 throughout reset; after release rvalid=0, err_count_o=0, busy_o=0.
- Write/read, Latency=1: write 32'hDEAD_BEEF to 0x1A10_0004 with be=4'hF and aid=3, then read the same address with aid=5 -> write response err=0, rid=3 one cycle after gnt; read rvalid one cycle after its gnt with rdata=32'hDEAD_BEEF, rid=5.
- Byte enables: preload 32'h1122_3344 at word 2, write 32'hAABB_CCDD with be=4'b0101, read back -> 32'h11BB_33DD.
- Errors: read 0x1A10_0400 (NumWords=256, out of range) and write 0x1A10_0002 (misaligned) -> both err=1, rdata=32'hBADC_AB1E, err_count_o=2, array unchanged.
- Back-pressure/outstanding, Latency=3, MaxOutstanding=2: req held high for 4 reads -> gnt on cycles 0,1, low on cycle 2, then regranted once the first rvalid retires. With stall_i pulsed high for 2 cycles, gnt=0 during the pulse while pending rvalids still arrive on schedule.
- Reset mid-flight: accept 2 reads at Latency=3, assert rst_i one cycle later -> no rvalid for those reads after release; a prior write's data is still readable.
